// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide engine for the execute stage.
// Divides use a radix-2 restoring loop on operand magnitudes with a signed
// fix-up on the final iteration. Multiplies form the full product from the
// latched operands and commit it after MUL_LAT cycles. Results stay on hi_o/lo_o
// until the next completed operation or reset.
module muldiv_unit #(
  parameter int WIDTH   = 32,  // even, >= 4
  parameter int MUL_LAT = 3    // >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_div_i,
  input  logic             start_mul_i,
  input  logic             sign_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz_o
);

  localparam int CNT_W  = $clog2(WIDTH) + 1;
  localparam int MCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(WIDTH - 1);
  localparam logic [MCNT_W-1:0] MUL_LAST = MCNT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic                sign_q, sign_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    quo_q, quo_d;     // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]    rem_q, rem_d;     // partial remainder (magnitude)
  logic [WIDTH-1:0]    dvs_q, dvs_d;     // divisor magnitude
  logic                quo_neg_q, quo_neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                dbz_q, dbz_d;

  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH:0]      rem_shift, rem_diff;
  logic [WIDTH-1:0]    quo_step, rem_step, quo_fix, rem_fix;
  logic [2*WIDTH-1:0]  mul_a, mul_b, product;

  // Operand magnitudes at accept; the most-negative value maps onto itself,
  // which is the correct unsigned magnitude 2^(WIDTH-1).
  always_comb begin
    a_mag = (sign_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag = (sign_i && b_i[WIDTH-1]) ? -b_i : b_i;
  end

  // One restoring-division step plus the signed fix-up of its result.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    if (rem_diff[WIDTH]) begin
      rem_step = rem_shift[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_step = rem_diff[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end
    quo_fix = quo_neg_q ? -quo_step : quo_step;
    rem_fix = rem_neg_q ? -rem_step : rem_step;
  end

  // Full-width product of the latched operands, sign- or zero-extended.
  always_comb begin
    mul_a   = {{WIDTH{sign_q & a_q[WIDTH-1]}}, a_q};
    mul_b   = {{WIDTH{sign_q & b_q[WIDTH-1]}}, b_q};
    product = mul_a * mul_b;
  end

  // Next-state, work-register and result-register logic.
  // NOTE: every variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcnt_d    = mcnt_q;
    sign_d    = sign_q;
    a_d       = a_q;
    b_d       = b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    case (state_q)
      IDLE: begin
        if (!annul_i && (start_div_i || start_mul_i)) begin
          state_d   = start_div_i ? DIV : MUL;  // divide wins a tie
          a_d       = a_i;
          b_d       = b_i;
          sign_d    = sign_i;
          quo_d     = a_mag;
          rem_d     = '0;
          dvs_d     = b_mag;
          quo_neg_d = sign_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rem_neg_d = sign_i & a_i[WIDTH-1];
          cnt_d     = '0;
          mcnt_d    = '0;
        end
      end
      DIV: begin
        if (annul_i) begin
          state_d = IDLE;
        end else if (dvs_q == '0) begin
          state_d = DONE;
          hi_d    = a_q;
          lo_d    = '1;
          dbz_d   = 1'b1;
        end else begin
          quo_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DIV_LAST) begin
            state_d = DONE;
            hi_d    = rem_fix;
            lo_d    = quo_fix;
            dbz_d   = 1'b0;
          end
        end
      end
      MUL: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          mcnt_d = mcnt_q + 1'b1;
          if (mcnt_q == MUL_LAST) begin
            state_d = DONE;
            hi_d    = product[2*WIDTH-1:WIDTH];
            lo_d    = product[WIDTH-1:0];
            dbz_d   = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: work registers are reset too, so no X can ever reach hi_o/lo_o.
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcnt_q    <= '0;
      sign_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcnt_q    <= mcnt_d;
      sign_q    <= sign_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy_o = (state_q == DIV) || (state_q == MUL);
  assign done_o = (state_q == DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign dbz_o  = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH=32, MUL_LAT=3).
// Expected results are pushed when an operation is launched and popped when
// done_o is seen; held outputs are tracked in 'held'.
`timescale 1ns/1ps
module tb_muldiv_unit;

  localparam int W  = 32;
  localparam int ML = 3;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } res_t;

  typedef struct {
    res_t res;
    int   lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_div, start_mul, sign, annul;
  logic [W-1:0] a, b;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  res_t held;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_div_i(start_div),
    .start_mul_i(start_mul),
    .sign_i     (sign),
    .annul_i    (annul),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .done_o     (done),
    .hi_o       (hi),
    .lo_o       (lo),
    .dbz_o      (dbz)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(logic [W-1:0] h, logic [W-1:0] l, logic z, int lat);
    exp_t e;
    e.res.hi  = h;
    e.res.lo  = l;
    e.res.dbz = z;
    e.lat     = lat;
    return e;
  endfunction

  // Reference model built on native 64-bit arithmetic.
  function automatic exp_t model(bit is_div, bit sgn, logic [W-1:0] x, logic [W-1:0] y);
    longint       sx, sy, q, r;
    logic [2*W-1:0] p;
    sx = sgn ? longint'(signed'(x)) : longint'(x);
    sy = sgn ? longint'(signed'(y)) : longint'(y);
    if (is_div) begin
      if (y == '0) return mk(x, {W{1'b1}}, 1'b1, 2);
      q = sx / sy;
      r = sx % sy;
      return mk(r[W-1:0], q[W-1:0], 1'b0, W + 1);
    end
    p = sx * sy;
    return mk(p[2*W-1:W], p[W-1:0], 1'b0, ML + 1);
  endfunction

  // Drive one accept cycle, then scramble the operands.
  task automatic launch(bit sd, bit sm, bit sgn, logic [W-1:0] x, logic [W-1:0] y);
    start_div = sd;
    start_mul = sm;
    sign      = sgn;
    a         = x;
    b         = y;
    step();
    start_div = 1'b0;
    start_mul = 1'b0;
    sign      = 1'($urandom_range(0, 1));
    a         = $urandom;
    b         = $urandom;
  endtask

  // Wait (bounded) for done_o; lat0 is the cycle index of the current cycle.
  task automatic collect(input int lat0, output res_t got, output int lat, output int bsy);
    lat = lat0;
    bsy = 0;
    while (!done && lat < 200) begin
      if (busy) bsy++;
      step();
      lat++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no done_o after %0d cycles", lat);
    end
    got = '{hi: hi, lo: lo, dbz: dbz};
  endtask

  task automatic test_reset();
    rst = 1'b1; start_div = 1'b0; start_mul = 1'b0; sign = 1'b0; annul = 1'b0;
    a = '0; b = '0;
    step();
    start_div = 1'b1; a = 32'd9; b = 32'd3;  // start under reset must be ignored
    step();
    start_div = 1'b0;
    rst = 1'b0;
    checks++;
    if ({busy, done, hi, lo, dbz} !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h dbz=%b, required all 0", busy, done, hi, lo, dbz);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_accept: busy=%b required 0", busy);
    end
    held = '0;
  endtask

  task automatic test_div();
    exp_t e; res_t got; int lat, bsy;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin sb_q.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, W + 1)); launch(1, 0, 1, 32'hFFFF_FFF9, 32'd2); end
        1: begin sb_q.push_back(mk(32'd2, 32'd14, 1'b0, W + 1)); launch(1, 0, 0, 32'd100, 32'd7); end
        default: begin sb_q.push_back(mk(32'd0, 32'h8000_0000, 1'b0, W + 1)); launch(1, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF); end
      endcase
      collect(1, got, lat, bsy);
      e = sb_q.pop_front();
      checks++;
      if (got !== e.res) begin
        failures++;
        $display("FAIL div_result[%0d]: hi=%h lo=%h dbz=%b, required hi=%h lo=%h dbz=%b", i, got.hi, got.lo, got.dbz, e.res.hi, e.res.lo, e.res.dbz);
      end
      checks++;
      if (lat != e.lat || bsy != W) begin
        failures++;
        $display("FAIL div_timing[%0d]: done at T+%0d busy %0d cycles, required T+%0d busy %0d", i, lat, bsy, e.lat, W);
      end
      held = e.res;
      step();
    end
  endtask

  task automatic test_mul();
    exp_t e; res_t got; int lat, bsy;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin sb_q.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, ML + 1)); launch(0, 1, 1, 32'hFFFF_FFFE, 32'd3); end
        1: begin sb_q.push_back(mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, ML + 1)); launch(0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); end
        default: begin sb_q.push_back(mk(32'h4000_0000, 32'h0, 1'b0, ML + 1)); launch(0, 1, 1, 32'h8000_0000, 32'h8000_0000); end
      endcase
      collect(1, got, lat, bsy);
      e = sb_q.pop_front();
      checks++;
      if (got !== e.res) begin
        failures++;
        $display("FAIL mul_result[%0d]: hi=%h lo=%h dbz=%b, required hi=%h lo=%h dbz=%b", i, got.hi, got.lo, got.dbz, e.res.hi, e.res.lo, e.res.dbz);
      end
      checks++;
      if (lat != e.lat || bsy != ML) begin
        failures++;
        $display("FAIL mul_timing[%0d]: done at T+%0d busy %0d cycles, required T+%0d busy %0d", i, lat, bsy, e.lat, ML);
      end
      held = e.res;
      step();
    end
  endtask

  task automatic test_dbz();
    exp_t e; res_t got; int lat, bsy;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin sb_q.push_back(mk(32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 2)); launch(1, 0, 1, 32'h1234_5678, 32'd0); end
      else        begin sb_q.push_back(mk(32'd0, 32'd4, 1'b0, ML + 1)); launch(0, 1, 0, 32'd2, 32'd2); end
      collect(1, got, lat, bsy);
      e = sb_q.pop_front();
      checks++;
      if (got !== e.res || lat != e.lat) begin
        failures++;
        $display("FAIL dbz_seq[%0d]: hi=%h lo=%h dbz=%b at T+%0d, required hi=%h lo=%h dbz=%b at T+%0d", i, got.hi, got.lo, got.dbz, lat, e.res.hi, e.res.lo, e.res.dbz, e.lat);
      end
      held = e.res;
      step();
    end
  endtask

  task automatic test_annul();
    exp_t e; res_t got; int lat, bsy, seen;
    // Annul alongside a start in IDLE suppresses the accept.
    start_div = 1'b1; annul = 1'b1; a = 32'd50; b = 32'd5;
    step();
    start_div = 1'b0; annul = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL annul_idle: busy=%b required 0", busy);
    end
    // Annul a divide at T+5.
    launch(1, 0, 0, 32'd100, 32'd7);
    repeat (4) step();
    annul = 1'b1;
    step();
    annul = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL annul_busy: busy=%b at T+6 required 0", busy);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      step();
    end
    checks++;
    if (seen != 0 || {hi, lo, dbz} !== held) begin
      failures++;
      $display("FAIL annul_hold: done pulses=%0d hi=%h lo=%h dbz=%b, required 0 pulses hi=%h lo=%h dbz=%b", seen, hi, lo, dbz, held.hi, held.lo, held.dbz);
    end
    // Both starts: divide wins; a multiply start while busy is ignored.
    e = model(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd9);
    sb_q.push_back(e);
    launch(1, 1, 1, 32'hFFFF_FF9C, 32'd9);
    start_mul = 1'b1;
    step();
    start_mul = 1'b0;
    collect(2, got, lat, bsy);
    e = sb_q.pop_front();
    checks++;
    if (got !== e.res || lat != e.lat) begin
      failures++;
      $display("FAIL both_start: hi=%h lo=%h at T+%0d, required hi=%h lo=%h at T+%0d", got.hi, got.lo, lat, e.res.hi, e.res.lo, e.lat);
    end
    held = e.res;
    // Annul and start during DONE are both ignored.
    annul = 1'b1; start_div = 1'b1;
    step();
    annul = 1'b0; start_div = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {hi, lo, dbz} !== held) begin
      failures++;
      $display("FAIL done_ignore: busy=%b done=%b hi=%h lo=%h, required busy=0 done=0 hi=%h lo=%h", busy, done, hi, lo, held.hi, held.lo);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; res_t got; int lat, bsy;
    launch(1, 0, 1, 32'hFFFF_0000, 32'd3);
    repeat (9) step();
    rst = 1'b1;
    step();
    checks++;
    if ({busy, done, hi, lo, dbz} !== '0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h dbz=%b, required all 0", busy, done, hi, lo, dbz);
    end
    rst  = 1'b0;
    held = '0;
    sb_q.push_back(model(1'b0, 1'b1, 32'hFFFF_FFF0, 32'd5));
    launch(0, 1, 1, 32'hFFFF_FFF0, 32'd5);
    collect(1, got, lat, bsy);
    e = sb_q.pop_front();
    checks++;
    if (got !== e.res || lat != e.lat) begin
      failures++;
      $display("FAIL after_reset: hi=%h lo=%h at T+%0d, required hi=%h lo=%h at T+%0d", got.hi, got.lo, lat, e.res.hi, e.res.lo, e.lat);
    end
    held = e.res;
    step();
  endtask

  task automatic test_back_to_back();
    exp_t e; res_t got; int lat, bsy;
    bit is_div, sgn;
    logic [W-1:0] x, y;
    for (int i = 0; i < 10; i++) begin
      is_div = 1'($urandom_range(0, 1));
      sgn    = 1'($urandom_range(0, 1));
      x      = $urandom;
      case ($urandom_range(0, 3))
        0:       y = '0;
        1:       y = W'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      sb_q.push_back(model(is_div, sgn, x, y));
      launch(is_div, !is_div, sgn, x, y);
      collect(1, got, lat, bsy);
      e = sb_q.pop_front();
      checks++;
      if (got !== e.res || lat != e.lat) begin
        failures++;
        $display("FAIL b2b[%0d] %s sgn=%0d a=%h b=%h: hi=%h lo=%h dbz=%b T+%0d, required hi=%h lo=%h dbz=%b T+%0d", i, is_div ? "div" : "mul", sgn, x, y, got.hi, got.lo, got.dbz, lat, e.res.hi, e.res.lo, e.res.dbz, e.lat);
      end
      held = e.res;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_div();
    test_mul();
    test_dbz();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
